alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Reservation station between the decoder and the integer ALU in the Tomasulo out-of-order core.
- Accepts decoded ALU micro-ops (operation, two operand value/tag pairs, destination ROB index) and holds them until both operands are valid.
- Snoops the common data bus (CDB) to wake up waiting operands.
- Issues one ready micro-op per cycle to the ALU, and tells the decoder to stall when all entries are occupied.

Parameters:
- DATA_W, 32, operand/data width.
- TAG_W, 4, operand tag width; MSB=1 encodes tagFree (4'b1000); tag = {1'b0, robIndex}.
- OP_W, 5, internal newop width.
- ENTRIES, 4, number of station entries (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- aluEnable  in  1  decoder presents a micro-op this cycle.
- aluData  in  (TAG_W-1)+2*TAG_W+2*DATA_W+OP_W (80)  packed {dest[TAG_W-2:0], tag2, data2, tag1, data1, newop}, MSB first.
- rsFull  out  1  all entries busy; decoder must hold aluEnable low.
- cdbValid  in  1  CDB broadcast valid.
- cdbTag  in  TAG_W  tag being broadcast.
- cdbData  in  DATA_W  broadcast result.
- flush  in  1  synchronous squash of all entries (misprediction recovery).
- issueValid  out  1  registered; micro-op on the issue bus is valid this cycle.
- issueOp  out  OP_W  registered operation.
- issueA  out  DATA_W  registered operand 1.
- issueB  out  DATA_W  registered operand 2.
- issueDest  out  TAG_W-1  registered destination ROB index.

Behaviour:
- Reset (async, on rst high): all entry busy bits = 0; issueValid = 0; issueOp, issueA, issueB, issueDest = 0; rsFull = 0. All state changes otherwise occur on the rising clk edge.
- Entry state: busy, op, V1, Q1, V2, Q2, dest. An operand is ready when Q == tagFree.
- rsFull is combinational from the busy bits: AND of all busy bits.
- Allocation: if aluEnable && !rsFull, the micro-op is written into the lowest-index non-busy entry. If aluEnable is high while rsFull is high, the op is dropped; this is a protocol violation and must be flagged by a bench assertion.
- Allocation forwarding: if cdbValid and cdbTag equals an incoming tag1 or tag2 (which is not tagFree) in the same cycle, the entry stores V = cdbData and Q = tagFree.
- Wakeup: every cycle with cdbValid high, each busy entry whose Q1 (or Q2) equals cdbTag takes V = cdbData and Q = tagFree. Both operands may wake in the same cycle. A cdbTag of tagFree never matches anything.
- Select: among busy entries that are ready on both operands at the start of the cycle, pick the lowest index.
  - On the edge: issue regs load {op, V1, V2, dest}, issueValid = 1, and the entry's busy bit clears.
  - If no entry is ready, issueValid = 0. The ALU always accepts; there is no backpressure.
- Latency:
  - An op allocated already ready at edge N issues at edge N+1, so issueValid is seen in cycle N+1.
  - An op woken by the CDB at edge N issues at edge N+1.
  - Minimum decoder-to-issue latency is 2 edges.
- Simultaneous events:
  - Issue and allocation in the same cycle while full: the slot being freed is not reusable that cycle, so rsFull stays high and the decoder stalls.
  - The freed slot is allocatable in the next cycle.
  - Allocation and wakeup of other entries proceed in parallel.
- Flush (priority over allocate, wakeup and issue): on the edge all busy bits = 0 and issueValid = 0; the incoming op that cycle is discarded.
- Reset mid-operation: all entries are immediately invalid, and no issue occurs after rst deasserts until a new allocation.
- Ordering: no age ordering between ready entries; correctness relies on ROB commit order.

Test Plan:
- Ready op: allocate ADD, tag1 = tag2 = 4'b1000, data1 = 5, data2 = 7, dest = 3 → next cycle issueValid = 1, issueA = 5, issueB = 7, issueDest = 3, issueOp = ADD; entry 0 freed; following cycle issueValid = 0.
- Wakeup: allocate op with tag1 = 4'b0010, then cdbValid = 1, cdbTag = 4'b0010, cdbData = 0xDEADBEEF two cycles later → issueA = 0xDEADBEEF one cycle after the broadcast; no issue before the broadcast.
- Same-cycle forward: allocate op with tag2 = 4'b0101 while the CDB broadcasts 4'b0101 with cdbData = 0x11 → issue next cycle with issueB = 0x11.
- Full/stall: fill 4 entries all waiting on tag 4'b0001 → rsFull = 1; broadcast 4'b0001 → entries issue in index order 0, 1, 2, 3 on consecutive cycles; rsFull drops the cycle after the first issue.
- Select priority: entries 1 and 3 become ready in the same cycle → entry 1 issues first and entry 3 the next cycle.
- Flush/reset: with 3 busy entries, pulse flush together with aluEnable → next cycle rsFull = 0, issueValid = 0 and no later issue; repeat with rst asserted mid-cycle → outputs zero immediately (asynchronous).

Source files
------------

// File: rtl/alu_reservation_station.sv
// Integer ALU reservation station: holds decoded micro-ops until both operands
// are valid, snoops the CDB for wakeups and issues one ready op per cycle.
module alu_reservation_station #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 5,
  parameter int ENTRIES = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          aluEnable,
  input  logic [(TAG_W-1)+2*TAG_W+2*DATA_W+OP_W-1:0]    aluData,
  output logic                                          rsFull,
  input  logic                                          cdbValid,
  input  logic [TAG_W-1:0]                              cdbTag,
  input  logic [DATA_W-1:0]                             cdbData,
  input  logic                                          flush,
  output logic                                          issueValid,
  output logic [OP_W-1:0]                               issueOp,
  output logic [DATA_W-1:0]                             issueA,
  output logic [DATA_W-1:0]                             issueB,
  output logic [TAG_W-2:0]                              issueDest
);

  localparam logic [TAG_W-1:0] TAG_FREE = {1'b1, {(TAG_W-1){1'b0}}};
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] r_busy;
  logic [OP_W-1:0]    r_op   [ENTRIES];
  logic [DATA_W-1:0]  r_v1   [ENTRIES];
  logic [TAG_W-1:0]   r_q1   [ENTRIES];
  logic [DATA_W-1:0]  r_v2   [ENTRIES];
  logic [TAG_W-1:0]   r_q2   [ENTRIES];
  logic [TAG_W-2:0]   r_dest [ENTRIES];

  logic [OP_W-1:0]    w_in_op;
  logic [DATA_W-1:0]  w_in_v1;
  logic [TAG_W-1:0]   w_in_q1;
  logic [DATA_W-1:0]  w_in_v2;
  logic [TAG_W-1:0]   w_in_q2;
  logic [TAG_W-2:0]   w_in_dest;
  logic               w_cdb_live;
  logic               w_fwd1;
  logic               w_fwd2;
  logic               w_sel_valid;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_alloc_valid;
  logic [IDX_W-1:0]   w_alloc_idx;

  assign w_in_op   = aluData[0 +: OP_W];
  assign w_in_v1   = aluData[OP_W +: DATA_W];
  assign w_in_q1   = aluData[OP_W+DATA_W +: TAG_W];
  assign w_in_v2   = aluData[OP_W+DATA_W+TAG_W +: DATA_W];
  assign w_in_q2   = aluData[OP_W+2*DATA_W+TAG_W +: TAG_W];
  assign w_in_dest = aluData[OP_W+2*DATA_W+2*TAG_W +: TAG_W-1];

  // A broadcast of tagFree must never match, so only tags with MSB clear are live.
  assign w_cdb_live = cdbValid && !cdbTag[TAG_W-1];
  assign w_fwd1     = w_cdb_live && (w_in_q1 == cdbTag);
  assign w_fwd2     = w_cdb_live && (w_in_q2 == cdbTag);
  assign rsFull     = &r_busy;

  // Lowest-index busy entry whose operands were both ready at the start of the cycle.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_busy[i] && (r_q1[i] == TAG_FREE) && (r_q2[i] == TAG_FREE)) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end else begin
        w_sel_valid = w_sel_valid;
      end
    end
  end

  // Lowest-index free entry; a slot freed by this cycle's issue is not reused until next cycle.
  always_comb begin
    w_alloc_valid = 1'b0;
    w_alloc_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_alloc_valid = aluEnable && !rsFull;
        w_alloc_idx   = IDX_W'(i);
      end else begin
        w_alloc_idx = w_alloc_idx;
      end
    end
  end

  // Entry storage: flush wins, then issue-clear, allocation and CDB wakeup per entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_op[i]   <= '0;
        r_v1[i]   <= '0;
        r_q1[i]   <= TAG_FREE;
        r_v2[i]   <= '0;
        r_q2[i]   <= TAG_FREE;
        r_dest[i] <= '0;
      end
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_sel_valid && (w_sel_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b0;
        end else if (w_alloc_valid && (w_alloc_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b1;
          r_op[i]   <= w_in_op;
          r_dest[i] <= w_in_dest;
          r_v1[i]   <= w_fwd1 ? cdbData : w_in_v1;
          r_q1[i]   <= w_fwd1 ? TAG_FREE : w_in_q1;
          r_v2[i]   <= w_fwd2 ? cdbData : w_in_v2;
          r_q2[i]   <= w_fwd2 ? TAG_FREE : w_in_q2;
        end else if (r_busy[i]) begin
          if (w_cdb_live && (r_q1[i] == cdbTag)) begin
            r_v1[i] <= cdbData;
            r_q1[i] <= TAG_FREE;
          end else begin
            r_q1[i] <= r_q1[i];
          end
          if (w_cdb_live && (r_q2[i] == cdbTag)) begin
            r_v2[i] <= cdbData;
            r_q2[i] <= TAG_FREE;
          end else begin
            r_q2[i] <= r_q2[i];
          end
        end else begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Issue bus registers toward the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issueValid <= 1'b0;
      issueOp    <= '0;
      issueA     <= '0;
      issueB     <= '0;
      issueDest  <= '0;
    end else if (flush) begin
      issueValid <= 1'b0;
    end else if (w_sel_valid) begin
      issueValid <= 1'b1;
      issueOp    <= r_op[w_sel_idx];
      issueA     <= r_v1[w_sel_idx];
      issueB     <= r_v2[w_sel_idx];
      issueDest  <= r_dest[w_sel_idx];
    end else begin
      issueValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station.
module tb_alu_reservation_station;

  logic        clk;
  logic        rst;
  logic        aluEnable;
  logic [79:0] aluData;
  logic        rsFull;
  logic        cdbValid;
  logic [3:0]  cdbTag;
  logic [31:0] cdbData;
  logic        flush;
  logic        issueValid;
  logic [4:0]  issueOp;
  logic [31:0] issueA;
  logic [31:0] issueB;
  logic [2:0]  issueDest;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] FREE = 4'b1000;

  alu_reservation_station dut (
    .clk(clk), .rst(rst), .aluEnable(aluEnable), .aluData(aluData), .rsFull(rsFull),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData), .flush(flush),
    .issueValid(issueValid), .issueOp(issueOp), .issueA(issueA), .issueB(issueB),
    .issueDest(issueDest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] pack(input logic [2:0] dest, input logic [3:0] t2,
                                       input logic [31:0] d2, input logic [3:0] t1,
                                       input logic [31:0] d1, input logic [4:0] op);
    return {dest, t2, d2, t1, d1, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; the decoder must never present an op while the station is full.
  task automatic tick();
    checks++;
    assert (!(aluEnable && rsFull && !rst)) else begin
      errors++;
      $error("FAIL protocol: observed aluEnable=%0b with rsFull=%0b expected no enable", aluEnable, rsFull);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [2:0] dest, input logic [3:0] t2, input logic [31:0] d2,
                       input logic [3:0] t1, input logic [31:0] d1, input logic [4:0] op);
    aluEnable = 1'b1;
    aluData   = pack(dest, t2, d2, t1, d1, op);
    tick();
    aluEnable = 1'b0;
    aluData   = '0;
  endtask

  task automatic bcast(input logic [3:0] tag, input logic [31:0] data);
    cdbValid = 1'b1;
    cdbTag   = tag;
    cdbData  = data;
    tick();
    cdbValid = 1'b0;
    cdbTag   = FREE;
    cdbData  = '0;
  endtask

  task automatic expect_issue(input string tag, input logic [2:0] dest, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] op);
    chk({tag, "_valid"}, {31'd0, issueValid}, 32'd1);
    chk({tag, "_dest"}, {29'd0, issueDest}, {29'd0, dest});
    chk({tag, "_a"}, issueA, a);
    chk({tag, "_b"}, issueB, b);
    chk({tag, "_op"}, {27'd0, issueOp}, {27'd0, op});
  endtask

  initial begin
    rst = 1'b1; aluEnable = 1'b0; aluData = '0; cdbValid = 1'b0;
    cdbTag = FREE; cdbData = '0; flush = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, issueValid}, 32'd0);
    chk("rst_full", {31'd0, rsFull}, 32'd0);
    chk("rst_a", issueA, 32'd0);
    chk("rst_dest", {29'd0, issueDest}, 32'd0);
    rst = 1'b0;
    tick();

    // Ready op: ADD 5 + 7 -> ROB 3
    alloc(3'd3, FREE, 32'd7, FREE, 32'd5, 5'd1);
    chk("ready_pre", {31'd0, issueValid}, 32'd0);
    tick();
    expect_issue("ready", 3'd3, 32'd5, 32'd7, 5'd1);
    chk("ready_full", {31'd0, rsFull}, 32'd0);
    tick();
    chk("ready_after", {31'd0, issueValid}, 32'd0);

    // Wakeup on tag 2, broadcast two cycles after allocation
    alloc(3'd1, FREE, 32'd9, 4'b0010, 32'd0, 5'd2);
    chk("wake_wait1", {31'd0, issueValid}, 32'd0);
    tick();
    chk("wake_wait2", {31'd0, issueValid}, 32'd0);
    bcast(4'b0010, 32'hDEADBEEF);
    chk("wake_bcast", {31'd0, issueValid}, 32'd0);
    tick();
    expect_issue("wake", 3'd1, 32'hDEADBEEF, 32'd9, 5'd2);
    tick();
    chk("wake_after", {31'd0, issueValid}, 32'd0);

    // Same-cycle forward of tag 5 into the allocating op
    cdbValid = 1'b1; cdbTag = 4'b0101; cdbData = 32'h11;
    alloc(3'd2, 4'b0101, 32'd0, FREE, 32'd4, 5'd3);
    cdbValid = 1'b0; cdbTag = FREE; cdbData = '0;
    tick();
    expect_issue("fwd", 3'd2, 32'd4, 32'h11, 5'd3);
    tick();
    chk("fwd_after", {31'd0, issueValid}, 32'd0);

    // Fill all four entries waiting on tag 1, then release them
    for (int i = 0; i < 4; i++) alloc(3'(i), FREE, 32'(i), 4'b0001, 32'd0, 5'd4);
    chk("full_set", {31'd0, rsFull}, 32'd1);
    chk("full_noissue", {31'd0, issueValid}, 32'd0);
    bcast(4'b0001, 32'h100);
    chk("full_still", {31'd0, rsFull}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_issue("full_order", 3'(i), 32'h100, 32'(i), 5'd4);
      chk("full_drop", {31'd0, rsFull}, 32'd0);
    end
    tick();
    chk("full_empty", {31'd0, issueValid}, 32'd0);

    // Select priority: entries 1 and 3 woken together by tag 7
    alloc(3'd0, FREE, 32'd0, 4'b0110, 32'd0, 5'd5);
    alloc(3'd1, FREE, 32'd1, 4'b0111, 32'd0, 5'd5);
    alloc(3'd2, FREE, 32'd2, 4'b0110, 32'd0, 5'd5);
    alloc(3'd3, FREE, 32'd3, 4'b0111, 32'd0, 5'd5);
    bcast(4'b0111, 32'h77);
    tick();
    expect_issue("prio_first", 3'd1, 32'h77, 32'd1, 5'd5);
    tick();
    expect_issue("prio_second", 3'd3, 32'h77, 32'd3, 5'd5);
    bcast(4'b0110, 32'h66);
    chk("prio_gap", {31'd0, issueValid}, 32'd0);
    tick();
    expect_issue("prio_e0", 3'd0, 32'h66, 32'd0, 5'd5);
    tick();
    expect_issue("prio_e2", 3'd2, 32'h66, 32'd2, 5'd5);
    tick();

    // Flush with three waiting entries plus a ready op presented the same cycle
    for (int i = 0; i < 3; i++) alloc(3'(i), FREE, 32'd0, 4'b0100, 32'd0, 5'd6);
    flush = 1'b1;
    alloc(3'd7, FREE, 32'd1, FREE, 32'd1, 5'd6);
    flush = 1'b0;
    chk("flush_full", {31'd0, rsFull}, 32'd0);
    chk("flush_valid", {31'd0, issueValid}, 32'd0);
    bcast(4'b0100, 32'h44);
    chk("flush_late1", {31'd0, issueValid}, 32'd0);
    tick();
    chk("flush_late2", {31'd0, issueValid}, 32'd0);
    tick();
    chk("flush_late3", {31'd0, issueValid}, 32'd0);

    // Asynchronous reset in the middle of a cycle while an issue is on the bus
    alloc(3'd1, FREE, 32'd0, 4'b0011, 32'd0, 5'd7);
    alloc(3'd2, FREE, 32'd0, 4'b0011, 32'd0, 5'd7);
    alloc(3'd6, FREE, 32'hBB, FREE, 32'hAA, 5'd7);
    tick();
    expect_issue("prerst", 3'd6, 32'hAA, 32'hBB, 5'd7);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, issueValid}, 32'd0);
    chk("arst_a", issueA, 32'd0);
    chk("arst_b", issueB, 32'd0);
    chk("arst_dest", {29'd0, issueDest}, 32'd0);
    chk("arst_op", {27'd0, issueOp}, 32'd0);
    tick();
    rst = 1'b0;
    bcast(4'b0011, 32'h33);
    tick();
    chk("arst_late1", {31'd0, issueValid}, 32'd0);
    tick();
    chk("arst_late2", {31'd0, issueValid}, 32'd0);
    alloc(3'd4, FREE, 32'd2, FREE, 32'd3, 5'd8);
    tick();
    expect_issue("post_rst", 3'd4, 32'd3, 32'd2, 5'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
